// File: rtl/pe_psum_acc.sv
// Per-column psum accumulator: bias preload, accumulate len psums, then round/shift/ReLU/saturate
// to one signed activation presented on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a start with non-zero length
// ACC   | accepting psums, o_psum_ready high
// OUT   | result held on o_out_data until i_out_ready
module pe_psum_acc #(
   parameter int COLUMN_OUT_WIDTH = 19,
   parameter int ACC_WIDTH        = 32,
   parameter int DATA_WIDTH       = 8,
   parameter int BIAS_WIDTH       = 16,
   parameter int CNT_WIDTH        = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic [CNT_WIDTH-1:0]        i_acc_len,
   input  logic [BIAS_WIDTH-1:0]       i_bias,
   input  logic [3:0]                  i_shift,
   input  logic                        i_relu,
   input  logic                        i_clear,
   input  logic                        i_psum_valid,
   input  logic [COLUMN_OUT_WIDTH-1:0] i_psum_column,
   output logic                        o_psum_ready,
   output logic                        o_busy,
   output logic                        o_out_valid,
   input  logic                        i_out_ready,
   output logic [DATA_WIDTH-1:0]       o_out_data
);

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   state_t                       state;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic [CNT_WIDTH-1:0]         count;
   logic [CNT_WIDTH-1:0]         len_q;
   logic [3:0]                   shift_q;
   logic                         relu_q;

   logic signed [ACC_WIDTH-1:0]  bias_ext;
   logic signed [ACC_WIDTH-1:0]  psum_ext;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic signed [ACC_WIDTH-1:0]  rounded;
   logic signed [ACC_WIDTH-1:0]  shifted;
   logic signed [ACC_WIDTH-1:0]  relu_val;
   logic [DATA_WIDTH-1:0]        result;
   logic [CNT_WIDTH-1:0]         count_inc;
   logic                         last_psum;

   assign bias_ext  = {{(ACC_WIDTH - BIAS_WIDTH){i_bias[BIAS_WIDTH-1]}}, i_bias};
   assign psum_ext  = {{(ACC_WIDTH - COLUMN_OUT_WIDTH){i_psum_column[COLUMN_OUT_WIDTH-1]}},
                       i_psum_column};
   assign acc_sum   = acc + psum_ext;
   assign count_inc = count + CNT_WIDTH'(1);
   assign last_psum = (count_inc == len_q);

   // Result is computed from acc_sum so the final psum lands in o_out_data on its accept edge.
   always_comb begin
      rounded = acc_sum;
      if (shift_q != 4'd0) begin
         rounded = acc_sum + (ACC_WIDTH'(1) << (shift_q - 4'd1));
      end
      shifted  = rounded >>> shift_q;
      relu_val = shifted;
      if (relu_q && (shifted < 0)) begin
         relu_val = '0;
      end
      if (relu_val > SAT_MAX) begin
         result = SAT_MAX[DATA_WIDTH-1:0];
      end else if (relu_val < SAT_MIN) begin
         result = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         result = relu_val[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         len_q        <= '0;
         shift_q      <= '0;
         relu_q       <= 1'b0;
         o_psum_ready <= 1'b0;
         o_busy       <= 1'b0;
         o_out_valid  <= 1'b0;
         o_out_data   <= '0;
      end else if (i_clear) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         o_psum_ready <= 1'b0;
         o_busy       <= 1'b0;
         o_out_valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start && (i_acc_len != '0)) begin
                  state        <= ACC;
                  acc          <= bias_ext;
                  count        <= '0;
                  len_q        <= i_acc_len;
                  shift_q      <= i_shift;
                  relu_q       <= i_relu;
                  o_psum_ready <= 1'b1;
                  o_busy       <= 1'b1;
               end
            end
            ACC: begin
               if (i_psum_valid) begin
                  acc   <= acc_sum;
                  count <= count_inc;
                  if (last_psum) begin
                     state        <= OUT;
                     o_psum_ready <= 1'b0;
                     o_out_valid  <= 1'b1;
                     o_out_data   <= result;
                  end
               end
            end
            OUT: begin
               if (i_out_ready) begin
                  state       <= IDLE;
                  o_out_valid <= 1'b0;
                  o_busy      <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               o_psum_ready <= 1'b0;
               o_busy       <= 1'b0;
               o_out_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_psum_acc.sv
// Scoreboard bench for pe_psum_acc: driver pushes reference results, a negedge monitor pops
// them on each output handshake and checks hold stability and ready/valid exclusivity.
module tb_pe_psum_acc;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_start = 1'b0;
   logic [7:0]  i_acc_len = '0;
   logic [15:0] i_bias = '0;
   logic [3:0]  i_shift = '0;
   logic        i_relu = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_psum_valid = 1'b0;
   logic [18:0] i_psum_column = '0;
   logic        o_psum_ready;
   logic        o_busy;
   logic        o_out_valid;
   logic        i_out_ready = 1'b0;
   logic [7:0]  o_out_data;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int job_ps[$];

   logic       prev_valid = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_data = '0;

   always #5 i_clk = ~i_clk;

   pe_psum_acc dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_acc_len(i_acc_len),
      .i_bias(i_bias), .i_shift(i_shift), .i_relu(i_relu), .i_clear(i_clear),
      .i_psum_valid(i_psum_valid), .i_psum_column(i_psum_column),
      .o_psum_ready(o_psum_ready), .o_busy(o_busy), .o_out_valid(o_out_valid),
      .i_out_ready(i_out_ready), .o_out_data(o_out_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-job arithmetic on plain ints (32-bit wrap matches the accumulator).
   function automatic logic [7:0] model(input int bias, input int sh, input bit relu);
      int s;
      s = bias;
      foreach (job_ps[i]) s = s + job_ps[i];
      if (sh > 0) s = s + (1 << (sh - 1));
      s = s >>> sh;
      if (relu && s < 0) s = 0;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s[7:0];
   endfunction

   always @(negedge i_clk) begin
      if (i_rst) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
      end else begin
         if (o_out_valid && o_psum_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_valid_overlap: psum_ready=1 while out_valid=1 at %0t", $time);
         end
         if (prev_valid && !prev_hs && o_out_valid) begin
            n_vec++;
            if (o_out_data !== prev_data) begin
               n_err++;
               $display("FAIL out_hold: got %0h, expected %0h at %0t", o_out_data, prev_data, $time);
            end
         end
         if (o_out_valid && i_out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_result: got %0h, expected none at %0t", o_out_data, $time);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (o_out_data !== e) begin
                  n_err++;
                  $display("FAIL result: got %0d, expected %0d at %0t",
                           $signed(o_out_data), $signed(e), $time);
               end
            end
         end
         prev_valid <= o_out_valid;
         prev_hs    <= o_out_valid && i_out_ready;
         prev_data  <= o_out_data;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_job(input int bias, input int sh, input bit relu, input bit gaps,
                          input int rdly, input bit mid_start, input bit extra_out);
      logic [7:0] e;
      int len;
      len = job_ps.size();
      e = model(bias, sh, relu);
      i_start = 1'b1;
      i_acc_len = len[7:0];
      i_bias = bias[15:0];
      i_shift = sh[3:0];
      i_relu = relu;
      i_out_ready = (rdly == 0);
      tick();
      i_start = 1'b0;
      check("psum_ready_after_start", {31'd0, o_psum_ready}, 32'd1);
      for (int i = 0; i < len; i++) begin
         if (gaps && i > 0) begin
            i_psum_valid = 1'b0;
            tick();
         end
         if (mid_start && i == 1) begin
            i_start = 1'b1;
            i_acc_len = 8'd1;
            i_bias = 16'd100;
            i_shift = 4'd3;
            i_relu = 1'b1;
         end
         i_psum_valid = 1'b1;
         i_psum_column = job_ps[i][18:0];
         if (i == len - 1) exp_q.push_back(e);
         tick();
         i_psum_valid = 1'b0;
         i_start = 1'b0;
      end
      check("out_valid_latency", {31'd0, o_out_valid}, 32'd1);
      check("psum_ready_in_out", {31'd0, o_psum_ready}, 32'd0);
      for (int k = 0; k < rdly; k++) begin
         if (extra_out && k == 0) begin
            i_psum_valid = 1'b1;
            i_psum_column = 19'h00123;
         end
         tick();
         i_psum_valid = 1'b0;
         check("out_valid_held", {31'd0, o_out_valid}, 32'd1);
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
      check("out_valid_after_hs", {31'd0, o_out_valid}, 32'd0);
      check("busy_after_hs", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #23;
      check("rst_psum_ready", {31'd0, o_psum_ready}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
      check("rst_out_data", {24'd0, o_out_data}, 32'd0);
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      tick();

      // Saturation high, then rounding
      job_ps = '{100, -20, 50};
      run_job(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run_job(0, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      // Negative rounding, ReLU, low saturation
      job_ps = '{-300};
      run_job(0, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      run_job(0, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      job_ps = '{-1000};
      run_job(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      // Bias, stalls, backpressure and a stray psum in OUT
      job_ps = '{10, 10, 10, 10};
      run_job(-5, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1);

      // Clear after 2 of 5 psums, with a start in the same cycle
      i_start = 1'b1;
      i_acc_len = 8'd5;
      i_bias = 16'd0;
      i_shift = 4'd0;
      i_relu = 1'b0;
      tick();
      i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i_psum_valid = 1'b1;
         i_psum_column = 19'd40;
         tick();
      end
      i_psum_valid = 1'b0;
      i_clear = 1'b1;
      i_start = 1'b1;
      i_acc_len = 8'd1;
      tick();
      i_clear = 1'b0;
      i_start = 1'b0;
      check("clear_busy", {31'd0, o_busy}, 32'd0);
      check("clear_psum_ready", {31'd0, o_psum_ready}, 32'd0);
      tick();
      check("clear_no_valid", {31'd0, o_out_valid}, 32'd0);
      check("clear_stays_idle", {31'd0, o_busy}, 32'd0);
      job_ps = '{7};
      run_job(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Async reset mid-OUT
      i_start = 1'b1;
      i_acc_len = 8'd1;
      tick();
      i_start = 1'b0;
      i_psum_valid = 1'b1;
      i_psum_column = 19'd1;
      tick();
      i_psum_valid = 1'b0;
      check("pre_rst_out_valid", {31'd0, o_out_valid}, 32'd1);
      #2 i_rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'd0, o_out_valid}, 32'd0);
      check("async_rst_busy", {31'd0, o_busy}, 32'd0);
      tick();
      i_rst = 1'b0;
      tick();

      // Zero-length start is ignored
      i_start = 1'b1;
      i_acc_len = 8'd0;
      tick();
      i_start = 1'b0;
      check("len0_busy", {31'd0, o_busy}, 32'd0);
      check("len0_psum_ready", {31'd0, o_psum_ready}, 32'd0);
      tick();

      // Start during ACC leaves config and count untouched
      job_ps = '{60, 61};
      run_job(0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

      for (int j = 0; j < 40; j++) begin
         int len, bias, sh, scale;
         len = $urandom_range(1, 12);
         bias = int'($urandom_range(0, 65535)) - 32768;
         sh = $urandom_range(0, 15);
         scale = $urandom_range(0, 2) == 0 ? 200 : 262143;
         job_ps.delete();
         for (int i = 0; i < len; i++)
            job_ps.push_back(int'($urandom_range(0, 2 * scale)) - scale);
         run_job(bias, sh, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 1'b0, 1'($urandom_range(0, 1)));
      end

      tick();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
